line_clear_scorer: RTL and testbench



---
 rtl/line_clear_scorer.sv | 155 +++++++++++++++
 tb/tb_line_clear_scorer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_scorer.sv
// Removes full rows from a settled playfield, compacts survivors downward, accumulates score.
// Latency ROWS+1+cleared_rows edges from start to done; start ignored while busy (no queueing).
// No downstream backpressure: results are held on the outputs until the next operation's SCORE edge.
module line_clear_scorer #(
    parameter int ROWS    = 22,
    parameter int COLS    = 10,
    parameter int SCORE_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROWS-1:0][COLS-1:0]      grid_in,
    input  logic                           clear_score,
    output logic [ROWS-1:0][COLS-1:0]      grid_out,
    output logic                           busy,
    output logic                           done,
    output logic [4:0]                     lines_last,
    output logic [7:0]                     lines_total,
    output logic [SCORE_W-1:0]             score
);

    localparam int PTR_W = $clog2(ROWS);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FILL,
        S_SCORE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ROWS-1:0][COLS-1:0] src;
    logic [ROWS-1:0][COLS-1:0] dst;
    logic [PTR_W-1:0]          rd;
    logic [PTR_W-1:0]          wr;
    logic [4:0]                cnt;

    logic                      row_full;
    logic [4:0]                cnt_scan;
    logic [SCORE_W:0]          score_sum;
    logic [8:0]                total_sum;

    function automatic logic [3:0] pts(input logic [4:0] n);
        logic [3:0] p;
        case (n)
            5'd0:    p = 4'd0;
            5'd1:    p = 4'd1;
            5'd2:    p = 4'd3;
            5'd3:    p = 4'd5;
            default: p = 4'd8;
        endcase
        return p;
    endfunction

    assign row_full  = &src[rd];
    // Count including the row under inspection, so the last SCAN cycle can pick FILL vs SCORE.
    assign cnt_scan  = cnt + {4'd0, row_full};
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(pts(cnt));
    assign total_sum = {1'b0, lines_total} + {4'd0, cnt};

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (rd == '0) begin
                    state_nxt = (cnt_scan != 5'd0) ? S_FILL : S_SCORE;
                end
            end
            S_FILL: begin
                // Fill rows cnt-1..0; the write pointer reaching row 0 marks the last one.
                if (wr == '0) begin
                    state_nxt = S_SCORE;
                end
            end
            S_SCORE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src         <= '0;
            dst         <= '0;
            rd          <= '0;
            wr          <= '0;
            cnt         <= '0;
            grid_out    <= '0;
            lines_last  <= '0;
            lines_total <= '0;
            score       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_score) begin
                        score       <= '0;
                        lines_total <= '0;
                    end
                    if (start) begin
                        src <= grid_in;
                        rd  <= LAST_ROW;
                        wr  <= LAST_ROW;
                        cnt <= '0;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        cnt <= cnt + 5'd1;
                    end else begin
                        dst[wr] <= src[rd];
                        wr      <= wr - 1'b1;
                    end
                    if (rd != '0) begin
                        rd <= rd - 1'b1;
                    end
                end
                S_FILL: begin
                    dst[wr] <= '0;
                    if (wr != '0) begin
                        wr <= wr - 1'b1;
                    end
                end
                S_SCORE: begin
                    grid_out    <= dst;
                    lines_last  <= cnt;
                    lines_total <= total_sum[8] ? 8'hFF : total_sum[7:0];
                    score       <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_scorer.sv
// Bench for line_clear_scorer: directed vector table, handshake/reset sequences,
// score saturation and randomized playfields checked against a queue-based model.
module tb_line_clear_scorer;

    localparam int ROWS = 22;
    localparam int COLS = 10;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef struct {
        grid_t g;
        grid_t exp_g;
        int    exp_lines;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear_score = 1'b0;
    grid_t       grid_in = '0;
    grid_t       grid_out;
    logic        busy;
    logic        done;
    logic [4:0]  lines_last;
    logic [7:0]  lines_total;
    logic [7:0]  score;

    int total = 0;
    int bad   = 0;
    int m_score = 0;
    int m_total = 0;

    line_clear_scorer #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .grid_in     (grid_in),
        .clear_score (clear_score),
        .grid_out    (grid_out),
        .busy        (busy),
        .done        (done),
        .lines_last  (lines_last),
        .lines_total (lines_total),
        .score       (score)
    );

    always #5 clk = ~clk;

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chkg(input string nm, input grid_t act, input grid_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: keep every non-full row bottom-up in a queue, restack from the bottom.
    function automatic void model_clear(input grid_t g, output grid_t o, output int n);
        logic [COLS-1:0] keep[$];
        keep = {};
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (g[r] != {COLS{1'b1}}) keep.push_back(g[r]);
        end
        o = '0;
        for (int i = 0; i < keep.size(); i++) o[ROWS-1-i] = keep[i];
        n = ROWS - keep.size();
    endfunction

    function automatic int pts(input int n);
        int tab[5] = '{0, 1, 3, 5, 8};
        return tab[(n > 4) ? 4 : n];
    endfunction

    // Runs one operation, checks score/total/latency/pulse against the model; returns the result grid.
    task automatic run_op(input grid_t g, input bit clr, output grid_t og, output int nl);
        grid_t eg;
        int    n;
        int    lat;
        @(negedge clk);
        grid_in     = g;
        start       = 1'b1;
        clear_score = clr;
        @(posedge clk);
        #1;
        start       = 1'b0;
        clear_score = 1'b0;
        grid_in     = ~g;
        if (clr) begin
            m_score = 0;
            m_total = 0;
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        og = grid_out;
        nl = int'(lines_last);
        model_clear(g, eg, n);
        m_total = (m_total + n > 255) ? 255 : m_total + n;
        m_score = (m_score + pts(n) > 255) ? 255 : m_score + pts(n);
        chki("latency", lat, ROWS + 1 + n);
        chki("score", int'(score), m_score);
        chki("lines_total", int'(lines_total), m_total);
        @(posedge clk);
        #1;
        chki("done_one_cycle", int'(done), 0);
        chki("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        tv_t   tv[5];
        grid_t g;
        grid_t og;
        grid_t eg;
        grid_t single_g;
        grid_t single_exp;
        grid_t tetris_g;
        int    nl;
        int    en;
        int    dcount;

        for (int i = 0; i < 5; i++) begin
            tv[i].g = '0;
            tv[i].exp_g = '0;
            tv[i].exp_lines = 0;
        end
        tv[1].g[21] = 10'h3FF; tv[1].g[20] = 10'h001;
        tv[1].exp_g[21] = 10'h001; tv[1].exp_lines = 1;
        tv[2].g[21] = 10'h3FF; tv[2].g[19] = 10'h3FF; tv[2].g[17] = 10'h3FF; tv[2].g[15] = 10'h3FF;
        tv[2].g[20] = 10'h200; tv[2].g[18] = 10'h010;
        tv[2].exp_g[21] = 10'h200; tv[2].exp_g[20] = 10'h010; tv[2].exp_lines = 4;
        tv[3].g = '1; tv[3].exp_lines = 22;
        tv[4].g[0] = 10'h3FF; tv[4].g[1] = 10'h123; tv[4].g[21] = 10'h2AA;
        tv[4].exp_g[1] = 10'h123; tv[4].exp_g[21] = 10'h2AA; tv[4].exp_lines = 1;
        single_g = tv[1].g;
        single_exp = tv[1].exp_g;
        tetris_g = tv[2].g;

        // Reset state
        #12;
        chki("rst_score", int'(score), 0);
        chki("rst_lines_total", int'(lines_total), 0);
        chkg("rst_grid_out", grid_out, '0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(tv[i].g, 1'b0, og, nl);
            chkg($sformatf("tv%0d_grid", i), og, tv[i].exp_g);
            chki($sformatf("tv%0d_lines", i), nl, tv[i].exp_lines);
        end

        // Repeated start and clear_score while busy are ignored
        @(negedge clk);
        grid_in = single_g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        grid_in = tetris_g;
        dcount = 0;
        for (int k = 1; k <= 60; k++) begin
            start = (k == 5 || k == 10);
            clear_score = (k == 8);
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        start = 1'b0;
        clear_score = 1'b0;
        m_score = m_score + 1;
        m_total = m_total + 1;
        chki("hs_done_count", dcount, 1);
        chkg("hs_grid", grid_out, single_exp);
        chki("hs_score", int'(score), m_score);
        chki("hs_lines_total", int'(lines_total), m_total);

        // Reset in the middle of SCAN
        @(negedge clk);
        grid_in = single_g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chki("mid_busy_before", int'(busy), 1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chki("mid_busy", int'(busy), 0);
        chki("mid_score", int'(score), 0);
        chki("mid_lines_total", int'(lines_total), 0);
        chkg("mid_grid", grid_out, '0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        chki("mid_no_done", dcount, 0);
        m_score = 0;
        m_total = 0;
        run_op(single_g, 1'b0, og, nl);
        chkg("post_rst_grid", og, single_exp);

        // Saturation: clear with start, climb to 250, then overflow
        run_op(tetris_g, 1'b1, og, nl);
        chki("clr_start_score", int'(score), 8);
        for (int i = 0; i < 30; i++) run_op(tetris_g, 1'b0, og, nl);
        run_op(single_g, 1'b0, og, nl);
        run_op(single_g, 1'b0, og, nl);
        chki("sat_pre_250", int'(score), 250);
        run_op(tetris_g, 1'b0, og, nl);
        chki("sat_255", int'(score), 255);
        run_op(single_g, 1'b0, og, nl);
        chki("sat_hold_255", int'(score), 255);
        chki("sat_lines_total", int'(lines_total), 131);

        // Randomized playfields against the queue model
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(2) == 0) g[r] = '1;
                else g[r] = COLS'($urandom);
            end
            model_clear(g, eg, en);
            run_op(g, 1'b0, og, nl);
            chkg($sformatf("rnd%0d_grid", it), og, eg);
            chki($sformatf("rnd%0d_lines", it), nl, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
